// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline register with a 2-entry skid buffer,
// a valid/ready handshake on both sides, a registered in_ready and a synchronous flush.
// Ports: clk and reset (async, active-low); flush;
//   in_valid/in_ready/in_payload (upstream side);
//   out_valid/out_ready/out_payload (downstream side);
//   stall_cnt/bubble_cnt (perf counters).
// Optional: define PIPE_STAGE_PERF_EN to build the counters; otherwise they are tied to 0.
module pipe_stage_elastic #(
  parameter int PAYLOAD_W = 107,
  parameter int CTRL_W    = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] r_skid;
  logic                 r_in_ready;

  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Control bits are masked while idle so a bubble never
  // carries stale write/branch enables downstream.
  assign out_payload = {r_main[PAYLOAD_W-1:CTRL_W],
                        r_main[CTRL_W-1:0] & {CTRL_W{out_valid}}};

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt  = S_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt    = S_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // in_ready is derived from the next state so it is a
  // plain flop and never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= in_payload;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= in_payload;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating; flush deliberately leaves the counts alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (!out_valid && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench for pipe_stage_elastic.
// Directed reset/stream/stall/flush/bubble cases, then a random phase.
module tb_pipe_stage_elastic;

  localparam int PW = 107;
  localparam int CW = 5;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_payload = '0;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] out_payload;
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;

  logic          s_rdy;
  logic          s_ov;
  logic [7:0]    s_pl;
  logic [1:0]    s_stall;
  logic [1:0]    s_bub;

  always #5 clk = ~clk;

  pipe_stage_elastic u_dut (
    .clk         (clk),
    .reset       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  pipe_stage_elastic #(
    .PAYLOAD_W (8),
    .CTRL_W    (2),
    .CNT_W     (2)
  ) u_sat (
    .clk         (clk),
    .reset       (rst_n),
    .flush       (1'b0),
    .in_valid    (1'b0),
    .in_ready    (s_rdy),
    .in_payload  (8'h00),
    .out_valid   (s_ov),
    .out_ready   (1'b0),
    .out_payload (s_pl),
    .stall_cnt   (s_stall),
    .bubble_cnt  (s_bub)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  logic [PW-1:0] sb[$];
  logic          acc = 1'b0;
  bit            skip_rdy = 1'b1;
  bit            ev;
  logic [PW-1:0] e;
  int unsigned   e_stall = 0;
  int unsigned   e_bub = 0;

  always @(negedge clk) begin
    acc = 1'b0;
    if (rst_n) begin
      ev = (sb.size() != 0);
      chk("out_valid", out_valid, ev);
      if (!skip_rdy) chk("in_ready", in_ready, sb.size() < 2);
      skip_rdy = 1'b0;
      if (!ev) chk("bubble_ctrl", out_payload[CW-1:0], 0);
      chk("stall_cnt", stall_cnt, PERF ? e_stall : 0);
      chk("bubble_cnt", bubble_cnt, PERF ? e_bub : 0);
      if (ev && out_ready) begin
        e = sb.pop_front();
        chk("payload", out_payload, e);
      end
      acc = in_valid && in_ready;
      if (flush) sb.delete();
      else if (acc) sb.push_back(in_payload);
      if (!ev) e_bub++;
      else if (!out_ready) e_stall++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] p);
    int k;
    in_valid   = 1'b1;
    in_payload = p;
    k = 0;
    do begin
      step();
      k++;
    end while (!acc && k < 50);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_pl", out_payload, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_bub", bubble_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // T2: back-to-back stream
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(PW'(i));
    repeat (3) step();

    // T3: stall fills skid, then drain
    send(PW'('hA));
    out_ready = 1'b0;
    send(PW'('hB));
    fork
      send(PW'('hC));
      begin
        repeat (3) step();
        chk("t3_full_rdy", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    repeat (4) step();

    // T4: flush while FULL
    out_ready = 1'b0;
    send(PW'('h21));
    send(PW'('h22));
    in_valid   = 1'b1;
    in_payload = PW'('hD);
    flush      = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_rdy", in_ready, 1);
    chk("t4_ov", out_valid, 0);
    chk("t4_ctrl", out_payload[CW-1:0], 0);
    out_ready = 1'b1;
    repeat (3) step();

    // flush in ONE with a payload that would fire
    out_ready = 1'b0;
    send(PW'('h31));
    in_valid   = 1'b1;
    in_payload = PW'('hE);
    flush      = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4b_ov", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) step();

    // flush with a completing out_fire
    send(PW'('h41));
    in_valid   = 1'b1;
    in_payload = PW'('h42);
    flush      = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4c_ov", out_valid, 0);
    repeat (2) step();

    // T5: ctrl=11111 then idle
    send({PW'(107'h5A5A5A5A), 5'b11111} >> 0);
    repeat (3) step();
    chk("t5_ctrl", out_payload[CW-1:0], 0);

    // T1: async reset while FULL
    out_ready = 1'b0;
    send(PW'('h51));
    send(PW'('h52));
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_ov", out_valid, 0);
    chk("t1_pl", out_payload, 0);
    chk("t1_stall", stall_cnt, 0);
    sb.delete();
    e_stall  = 0;
    e_bub    = 0;
    skip_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("t1_rdy", in_ready, 1);

    // random traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid   = 1'($urandom_range(0, 1));
        in_payload = PW'({$urandom, $urandom,
                          $urandom, $urandom});
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();

    chk("sb_drain", sb.size(), 0);
    chk("sat_bub", s_bub, PERF ? 3 : 0);
    chk("sat_stall", s_stall, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
